// File: rtl/alu_pkg.sv
// Shared opcodes and types for the KGP-RISC execute-stage ALU.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_COMP  = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_MULT  = 4'b0100;
    localparam logic [3:0] OP_MULTU = 4'b0101;
    localparam logic [3:0] OP_SHLL  = 4'b0110;
    localparam logic [3:0] OP_SHRL  = 4'b0111;
    localparam logic [3:0] OP_SHRA  = 4'b1000;
    localparam logic [3:0] OP_SHLLV = 4'b1001;
    localparam logic [3:0] OP_SHRLV = 4'b1010;
    localparam logic [3:0] OP_SHRAV = 4'b1011;

    typedef enum logic [1:0] {
        SH_LEFT   = 2'd0,
        SH_LRIGHT = 2'd1,
        SH_ARIGHT = 2'd2
    } shmode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: left, logical right or arithmetic right.
module alu_shifter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         operand,
    input  logic [$clog2(WIDTH)-1:0] amount,
    input  alu_pkg::shmode_e         mode,
    output logic [WIDTH-1:0]         result
);
    import alu_pkg::*;

    always_comb begin
        result = operand << amount;
        case (mode)
            SH_LRIGHT: result = operand >> amount;
            SH_ARIGHT: result = $signed(operand) >>> amount;
            default:   ;
        endcase
    end

endmodule

// File: rtl/risc_alu.sv
// KGP-RISC execute-stage ALU: arithmetic, logic, multiply and shifts with
// registered result, multiply high word and branch flags (latency 1).
module risc_alu #(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         operand0,
    input  logic [WIDTH-1:0]         operand1,
    input  logic [3:0]               control,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic [WIDTH-1:0]         result,
    output logic [WIDTH-1:0]         result1,
    output logic                     zFlag,
    output logic                     carryFlag,
    output logic                     signFlag,
    output logic                     overflowFlag
);
    import alu_pkg::*;

    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       neg;
    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   prod_u;
    logic [SW-1:0]        sh_amt;
    shmode_e              sh_mode;
    logic [WIDTH-1:0]     sh_res;
    logic [WIDTH-1:0]     res_d;
    logic [WIDTH-1:0]     res1_d;
    logic                 is_mul;
    logic                 z_d, c_d, s_d, v_d;

    assign sum = {1'b0, operand0} + {1'b0, operand1};
    assign neg = {1'b0, ~operand1} + (WIDTH+1)'(1);

    // Low 2W bits of the sign-extended product equal the signed product.
    assign prod_s = {{WIDTH{operand0[MSB]}}, operand0} * {{WIDTH{operand1[MSB]}}, operand1};
    assign prod_u = {{WIDTH{1'b0}}, operand0} * {{WIDTH{1'b0}}, operand1};

    always_comb begin
        sh_mode = SH_LEFT;
        sh_amt  = shamt;
        case (control)
            OP_SHRL, OP_SHRLV: sh_mode = SH_LRIGHT;
            OP_SHRA, OP_SHRAV: sh_mode = SH_ARIGHT;
            default:           ;
        endcase
        if (control == OP_SHLLV || control == OP_SHRLV || control == OP_SHRAV)
            sh_amt = operand1[SW-1:0];
    end

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .operand (operand0),
        .amount  (sh_amt),
        .mode    (sh_mode),
        .result  (sh_res)
    );

    always_comb begin
        res_d  = '0;
        res1_d = '0;
        c_d    = 1'b0;
        v_d    = 1'b0;
        case (control)
            OP_ADD: begin
                res_d = sum[MSB:0];
                c_d   = sum[WIDTH];
                v_d   = (operand0[MSB] == operand1[MSB]) && (sum[MSB] != operand0[MSB]);
            end
            OP_COMP: begin
                res_d = neg[MSB:0];
                c_d   = neg[WIDTH];
                v_d   = (operand1 == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_AND:   res_d = operand0 & operand1;
            OP_XOR:   res_d = operand0 ^ operand1;
            OP_MULT:  {res1_d, res_d} = prod_s;
            OP_MULTU: {res1_d, res_d} = prod_u;
            OP_SHLL, OP_SHRL, OP_SHRA,
            OP_SHLLV, OP_SHRLV, OP_SHRAV: res_d = sh_res;
            default:  ;
        endcase
    end

    // res1_d is zero for non-multiply ops, so one zero test covers both cases.
    assign is_mul = (control == OP_MULT) || (control == OP_MULTU);
    assign z_d    = ~|{res1_d, res_d};
    assign s_d    = is_mul ? res1_d[MSB] : res_d[MSB];

    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            result1      <= '0;
            zFlag        <= 1'b0;
            carryFlag    <= 1'b0;
            signFlag     <= 1'b0;
            overflowFlag <= 1'b0;
        end else begin
            result       <= res_d;
            result1      <= res1_d;
            zFlag        <= z_d;
            carryFlag    <= c_d;
            signFlag     <= s_d;
            overflowFlag <= v_d;
        end
    end

endmodule

// File: tb/tb_risc_alu.sv
// Randomized bench for risc_alu against an arithmetic reference model,
// plus literal vectors that pin both the model and the DUT.
module tb_risc_alu;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] r1;
        logic        z;
        logic        c;
        logic        s;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] operand0 = '0;
    logic [31:0] operand1 = '0;
    logic [3:0]  control = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] result, result1;
    logic        zFlag, carryFlag, signFlag, overflowFlag;

    exp_t got;
    exp_t exp_q;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    risc_alu dut (
        .clk          (clk),
        .rst          (rst),
        .operand0     (operand0),
        .operand1     (operand1),
        .control      (control),
        .shamt        (shamt),
        .result       (result),
        .result1      (result1),
        .zFlag        (zFlag),
        .carryFlag    (carryFlag),
        .signFlag     (signFlag),
        .overflowFlag (overflowFlag)
    );

    assign got = {result, result1, zFlag, carryFlag, signFlag, overflowFlag};

    function automatic exp_t model(logic [3:0] ctl, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
        exp_t        e;
        longint      sa, sb, t;
        logic [63:0] p;
        logic [32:0] u;
        e  = '0;
        p  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ctl)
            4'd0: begin
                u   = {1'b0, a} + {1'b0, b};
                e.r = u[31:0];
                e.c = u[32];
                t   = sa + sb;
                e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd1: begin
                t   = -sb;
                e.r = t[31:0];
                e.c = (b == 32'd0);
                e.v = (t > 64'sd2147483647);
            end
            4'd2:  e.r = a & b;
            4'd3:  e.r = a ^ b;
            4'd4:  begin t = sa * sb; p = t; {e.r1, e.r} = p; end
            4'd5:  begin p = {32'd0, a} * {32'd0, b}; {e.r1, e.r} = p; end
            4'd6:  e.r = a << sh;
            4'd7:  e.r = a >> sh;
            4'd8:  e.r = $signed(a) >>> sh;
            4'd9:  e.r = a << b[4:0];
            4'd10: e.r = a >> b[4:0];
            4'd11: e.r = $signed(a) >>> b[4:0];
            default: ;
        endcase
        if (ctl == 4'd4 || ctl == 4'd5) begin
            e.z = (p == 64'd0);
            e.s = e.r1[31];
        end else begin
            e.z = (e.r == 32'd0);
            e.s = e.r[31];
        end
        return e;
    endfunction

    task automatic chk(string nm, exp_t act, exp_t want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got r=%h r1=%h zcsv=%b%b%b%b, want r=%h r1=%h zcsv=%b%b%b%b",
                      nm, act.r, act.r1, act.z, act.c, act.s, act.v,
                      want.r, want.r1, want.z, want.c, want.s, want.v);
    endtask

    always @(posedge clk)
        exp_q <= rst ? exp_t'(0) : model(control, operand0, operand1, shamt);

    always @(negedge clk)
        if (chk_en) chk("cycle", got, exp_q);

    task automatic dir(string nm, logic [3:0] ctl, logic [31:0] a, logic [31:0] b,
                       logic [4:0] sh, logic [31:0] r, logic [31:0] r1, logic [3:0] zcsv);
        exp_t want;
        want = {r, r1, zcsv};
        chk({nm, "/model"}, model(ctl, a, b, sh), want);
        control  = ctl;
        operand0 = a;
        operand1 = b;
        shamt    = sh;
        @(posedge clk);
        #1;
        chk(nm, got, want);
    endtask

    initial begin
        control  = 4'd0;
        operand0 = 32'd5;
        operand1 = 32'd6;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset", got, exp_t'(0));
        rst = 1'b0;

        dir("add_neg",   4'd0, 32'hFFFFFFFD, 32'h1, 5'd0, 32'hFFFFFFFE, 32'h0, 4'b0010);
        dir("add_ovf",   4'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 32'h0, 4'b0011);
        dir("add_carry", 4'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0,        32'h0, 4'b1100);
        dir("comp_m1",   4'd1, 32'h1234,     32'hFFFFFFFF, 5'd0, 32'h1, 32'h0, 4'b0000);
        dir("comp_0",    4'd1, 32'h1234,     32'h0, 5'd0, 32'h0,        32'h0, 4'b1100);
        dir("comp_min",  4'd1, 32'h1234,     32'h80000000, 5'd0, 32'h80000000, 32'h0, 4'b0011);
        dir("and",       4'd2, 32'h3, 32'h1, 5'd0, 32'h1, 32'h0, 4'b0000);
        dir("xor",       4'd3, 32'h3, 32'h1, 5'd0, 32'h2, 32'h0, 4'b0000);
        dir("mult_s",    4'd4, 32'h3, 32'h1, 5'd0, 32'h3, 32'h0, 4'b0000);
        dir("multu_s",   4'd5, 32'h3, 32'h1, 5'd0, 32'h3, 32'h0, 4'b0000);
        dir("mult_neg",  4'd4, 32'hFFFFFFF5, 32'h2, 5'd0, 32'hFFFFFFEA, 32'hFFFFFFFF, 4'b0010);
        dir("multu_neg", 4'd5, 32'hFFFFFFF5, 32'h2, 5'd0, 32'hFFFFFFEA, 32'h00000001, 4'b0000);
        dir("mult_hi0",  4'd5, 32'h0, 32'hFFFFFFFF, 5'd0, 32'h0, 32'h0, 4'b1000);
        dir("shll",      4'd6,  32'hFFFFFFF5, 32'h5,  5'd2, 32'hFFFFFFD4, 32'h0, 4'b0010);
        dir("shrl",      4'd7,  32'hFFFFFFF5, 32'h5,  5'd2, 32'h3FFFFFFD, 32'h0, 4'b0000);
        dir("shra",      4'd8,  32'hFFFFFFF5, 32'h5,  5'd2, 32'hFFFFFFFD, 32'h0, 4'b0010);
        dir("shllv",     4'd9,  32'hFFFFFFF5, 32'h2,  5'd7, 32'hFFFFFFD4, 32'h0, 4'b0010);
        dir("shrlv",     4'd10, 32'hFFFFFFF5, 32'h2,  5'd7, 32'h3FFFFFFD, 32'h0, 4'b0000);
        dir("shrav",     4'd11, 32'hFFFFFFF5, 32'h2,  5'd7, 32'hFFFFFFFD, 32'h0, 4'b0010);
        dir("shllv_hi",  4'd9,  32'hFFFFFFF5, 32'h22, 5'd7, 32'hFFFFFFD4, 32'h0, 4'b0010);
        dir("shrlv_hi",  4'd10, 32'hFFFFFFF5, 32'h22, 5'd7, 32'h3FFFFFFD, 32'h0, 4'b0000);
        dir("shrav_hi",  4'd11, 32'hFFFFFFF5, 32'h22, 5'd7, 32'hFFFFFFFD, 32'h0, 4'b0010);
        dir("shll_zero", 4'd6,  32'h8000A5A5, 32'h3,  5'd0, 32'h8000A5A5, 32'h0, 4'b0010);
        dir("shrav_zero",4'd11, 32'h8000A5A5, 32'h20, 5'd9, 32'h8000A5A5, 32'h0, 4'b0010);
        dir("op_c",      4'd12, 32'hFFFFFFFF, 32'h1, 5'd3, 32'h0, 32'h0, 4'b1000);
        dir("op_f",      4'd15, 32'h7, 32'h9, 5'd1, 32'h0, 32'h0, 4'b1000);

        // Reset asserted alongside a live op must win.
        control  = 4'd4;
        operand0 = 32'hFFFFFFFF;
        operand1 = 32'hFFFFFFFF;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_override", got, exp_t'(0));
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            control = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0:       operand0 = 32'h0;
                1:       operand0 = 32'h80000000;
                2:       operand0 = 32'hFFFFFFFF;
                3:       operand0 = 32'h7FFFFFFF;
                default: operand0 = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       operand1 = 32'h0;
                1:       operand1 = 32'h80000000;
                2:       operand1 = 32'hFFFFFFFF;
                3:       operand1 = 32'h1;
                default: operand1 = $urandom;
            endcase
            shamt = 5'($urandom);
            rst   = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/risc_alu.md
Name: risc_alu

Overview:
- 32-bit integer ALU for the KGP-RISC datapath execute stage.
- Performs add, two's complement, logic, signed/unsigned multiply and six shift variants.
- Results and flags are registered: one clock of latency, synchronous active-high reset.
- Flags feed the branch unit; result1 carries the high word of multiply products.

Parameters:
- WIDTH, 32, operand/result width; shift amounts are log2(WIDTH) = 5 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- operand0  input  32  first operand (rs); the value shifted by all shift ops
- operand1  input  32  second operand (rt); low 5 bits are the variable shift amount
- control  input  4  operation select
- shamt  input  5  immediate shift amount
- result  output  32  registered result (low word for multiply)
- result1  output  32  registered high word of multiply; 0 for all other ops
- zFlag  output  1  registered zero flag
- carryFlag  output  1  registered carry flag
- signFlag  output  1  registered sign flag
- overflowFlag  output  1  registered signed-overflow flag

Behaviour:
- Inputs are sampled at every rising clk edge; outputs reflect those inputs after that edge (latency 1). There is no handshake; a new op may be issued every cycle.
- When rst=1 at an edge, all six outputs become 0; this overrides any op in flight. While rst stays high, outputs hold 0.
- Control encoding:
  - 0000 ADD: operand0+operand1.
  - 0001 COMP: result = ~operand1+1; operand0 is ignored.
  - 0010 AND.
  - 0011 XOR.
  - 0100 MULT: signed 32x32 -> 64; {result1,result} = product.
  - 0101 MULTU: unsigned 32x32 -> 64; {result1,result} = product.
  - 0110 SHLL: operand0 << shamt.
  - 0111 SHRL: operand0 >> shamt, logical.
  - 1000 SHRA: operand0 >>> shamt, arithmetic.
  - 1001 SHLLV, 1010 SHRLV, 1011 SHRAV: as 0110/0111/1000, but the amount is operand1[4:0] and operand1[31:5] is ignored.
  - 1100-1111: result=0, result1=0, all flags 0.
- Shift amount 0 passes operand0 through unchanged.
- zFlag:
  - MULT/MULTU: 1 iff the full 64-bit product is 0.
  - Otherwise: 1 iff the 32-bit result is 0 (including ops 1100-1111).
- signFlag:
  - MULT/MULTU: result1[31].
  - Otherwise: result[31].
- carryFlag:
  - ADD: bit 32 of the 33-bit unsigned sum.
  - COMP: bit 32 of (~operand1 + 1), which is 1 only when operand1=0.
  - All other ops: 0.
- overflowFlag:
  - ADD: set when both operands have the same sign and result[31] differs from it.
  - COMP: set iff operand1=0x80000000.
  - All other ops: 0.
- Multiply is purely combinational into the output register; there are no multi-cycle states.

Decomposition:
- Shared package alu_pkg holds:
  - 4-bit opcode localparams: OP_ADD, OP_COMP, OP_AND, OP_XOR, OP_MULT, OP_MULTU, OP_SHLL, OP_SHRL, OP_SHRA, OP_SHLLV, OP_SHRLV, OP_SHRAV.
  - WIDTH default.
- One sub-module, alu_shifter:
  - Inputs: operand, 5-bit amount, 2-bit mode (left / logical right / arithmetic right).
  - Purely combinational.
- The top level selects the amount source, does arithmetic and logic, computes flags, and registers the outputs.

Test Plan:
- Reset: drive any op with rst=1 for one edge -> all outputs 0. Release rst -> outputs follow inputs one cycle later.
- Add: operand0=0xFFFFFFFD, operand1=1, ADD -> result 0xFFFFFFFE, z0 c0 s1 v0.
  - operand0=0x7FFFFFFF, operand1=1 -> result 0x80000000, v1 s1 c0.
  - operand0=0xFFFFFFFF, operand1=1 -> result 0, z1 c1 v0.
- COMP:
  - operand1=0xFFFFFFFF -> result 1, c0 v0.
  - operand1=0 -> result 0, z1 c1.
  - operand1=0x80000000 -> result 0x80000000, v1.
- Logic: operand0=3, operand1=1:
  - AND -> 1.
  - XOR -> 2.
  - MULT -> result 3, result1 0.
  - MULTU -> result 3, result1 0.
- Signed vs unsigned multiply: operand0=0xFFFFFFF5, operand1=2:
  - MULT -> result 0xFFFFFFEA, result1 0xFFFFFFFF, s1.
  - MULTU -> result 0xFFFFFFEA, result1 0x00000001, s0.
- Shifts: operand0=0xFFFFFFF5, shamt=2, operand1=2:
  - SHLL and SHLLV -> 0xFFFFFFD4.
  - SHRL and SHRLV -> 0x3FFFFFFD.
  - SHRA and SHRAV -> 0xFFFFFFFD.
  - With operand1=0x22 the variable shifts give the same results.
  - Control 1100 -> result 0, z1.
